// File: rtl/dcache_ctrl_if.sv
// Pipeline-side and memory-side signal bundle for the data cache.
// The cache takes the slave view; the pipeline/memory side takes master.
interface dcache_ctrl_if;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_rd;
   logic        cpu_wr;
   logic [2:0]  cpu_width;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   modport master (
      output cpu_addr, cpu_wdata, cpu_rd, cpu_wr, cpu_width,
      output mem_ack, mem_rdata,
      input  cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr,
      input  mem_wdata, mem_wstrb, hit_count, miss_count
   );

   modport slave (
      input  cpu_addr, cpu_wdata, cpu_rd, cpu_wr, cpu_width,
      input  mem_ack, mem_rdata,
      output cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr,
      output mem_wdata, mem_wstrb, hit_count, miss_count
   );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through, no-write-allocate data cache.
// Hits are served combinationally; read misses refill a whole line.
module dcache_ctrl #(
   parameter int SETS       = 16,
   parameter int LINE_WORDS = 4
) (
   input logic         clk,
   input logic         rst,
   dcache_ctrl_if.slave bus
);
   localparam int WB = $clog2(LINE_WORDS);
   localparam int IB = $clog2(SETS);
   localparam int TW = 30 - WB - IB;
   localparam logic [WB-1:0] LAST = WB'(LINE_WORDS - 1);

   typedef enum logic [1:0] {IDLE, REFILL, WSTORE, DONE} state_t;

   state_t         state;
   state_t         state_nx;
   logic [WB-1:0]  cnt;
   logic [SETS-1:0] valid;
   logic [TW-1:0]  tags  [SETS];
   logic [31:0]    lines [SETS][LINE_WORDS];
   logic [31:0]    hits;
   logic [31:0]    misses;

   logic [1:0]     off;
   logic [WB-1:0]  word;
   logic [IB-1:0]  index;
   logic [TW-1:0]  tag;
   logic           hit;
   logic [31:0]    cur;
   logic [7:0]     bsel;
   logic [15:0]    hsel;
   logic [31:0]    ext;
   logic [31:0]    lane;
   logic [3:0]     strb;

   logic           stall;
   logic           req;
   logic           we;
   logic [31:0]    maddr;
   logic [31:0]    mwdata;
   logic [3:0]     mstrb;
   logic [31:0]    rdata;

   assign off   = bus.cpu_addr[1:0];
   assign word  = bus.cpu_addr[2 +: WB];
   assign index = bus.cpu_addr[2 + WB +: IB];
   assign tag   = bus.cpu_addr[31 -: TW];
   assign hit   = valid[index] && (tags[index] == tag);
   assign cur   = lines[index][word];

   always_comb begin
      bsel = cur[{off, 3'b000} +: 8];
      hsel = off[1] ? cur[31:16] : cur[15:0];
      unique case (bus.cpu_width)
         3'b000:  ext = {{24{bsel[7]}}, bsel};
         3'b001:  ext = {{16{hsel[15]}}, hsel};
         3'b100:  ext = {24'd0, bsel};
         3'b101:  ext = {16'd0, hsel};
         default: ext = cur;
      endcase
   end

   always_comb begin
      unique case (bus.cpu_width[1:0])
         2'b00: begin
            lane = {4{bus.cpu_wdata[7:0]}};
            strb = 4'b0001 << off;
         end
         2'b01: begin
            lane = {2{bus.cpu_wdata[15:0]}};
            strb = 4'b0011 << {off[1], 1'b0};
         end
         default: begin
            lane = bus.cpu_wdata;
            strb = 4'b1111;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      stall    = 1'b0;
      req      = 1'b0;
      we       = 1'b0;
      maddr    = '0;
      mwdata   = '0;
      mstrb    = '0;
      rdata    = '0;
      unique case (state)
         IDLE: begin
            if (bus.cpu_wr) begin
               stall    = 1'b1;
               state_nx = WSTORE;
            end else if (bus.cpu_rd) begin
               if (hit) begin
                  rdata = ext;
               end else begin
                  stall    = 1'b1;
                  state_nx = REFILL;
               end
            end
         end
         REFILL: begin
            stall = 1'b1;
            req   = 1'b1;
            maddr = {tag, index, cnt, 2'b00};
            if (bus.mem_ack && cnt == LAST) state_nx = DONE;
         end
         WSTORE: begin
            stall  = 1'b1;
            req    = 1'b1;
            we     = 1'b1;
            maddr  = {bus.cpu_addr[31:2], 2'b00};
            mwdata = lane;
            mstrb  = strb;
            if (bus.mem_ack) state_nx = DONE;
         end
         DONE: begin
            state_nx = IDLE;
            if (bus.cpu_rd && !bus.cpu_wr) rdata = ext;
         end
         default: state_nx = IDLE;
      endcase
      // keep the memory port quiet while reset is held
      if (rst) begin
         req    = 1'b0;
         we     = 1'b0;
         maddr  = '0;
         mwdata = '0;
         mstrb  = '0;
         rdata  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid  <= '0;
         cnt    <= '0;
         hits   <= '0;
         misses <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.cpu_rd && !bus.cpu_wr) begin
                  if (hit) begin
                     if (~&hits) hits <= hits + 32'd1;
                  end else begin
                     if (~&misses) misses <= misses + 32'd1;
                     cnt          <= '0;
                     valid[index] <= 1'b0;
                  end
               end
            end
            REFILL: begin
               if (bus.mem_ack) begin
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST) valid[index] <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == IDLE && bus.cpu_wr && hit) begin
            for (int i = 0; i < 4; i++)
               if (strb[i]) lines[index][word][8*i +: 8] <= lane[8*i +: 8];
         end
         if (state == REFILL && bus.mem_ack) begin
            lines[index][cnt] <= bus.mem_rdata;
            if (cnt == LAST) tags[index] <= tag;
         end
      end
   end

   assign bus.cpu_rdata  = rdata;
   assign bus.cpu_stall  = stall;
   assign bus.mem_req    = req;
   assign bus.mem_we     = we;
   assign bus.mem_addr   = maddr;
   assign bus.mem_wdata  = mwdata;
   assign bus.mem_wstrb  = mstrb;
   assign bus.hit_count  = hits;
   assign bus.miss_count = misses;
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a word-wide memory responder.
// Inputs change #1 after the rising edge; outputs sampled on the falling edge.
module tb_dcache_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;

   dcache_ctrl_if bus ();

   dcache_ctrl #(.SETS(16), .LINE_WORDS(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [31:0] mem_m [logic [31:0]];
   logic [31:0] rq_addr [$];
   logic        rq_we [$];
   logic [31:0] l_wdata;
   logic [3:0]  l_wstrb;
   logic [31:0] l_rdata;
   int          l_stall;
   int          stab_err;

   function automatic logic [31:0] memval(input logic [31:0] a);
      if (mem_m.exists(a)) return mem_m[a];
      return {16'hA5A5, a[15:0]};
   endfunction

   task automatic wmem(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
      logic [31:0] v;
      v = memval(a);
      for (int i = 0; i < 4; i++) if (s[i]) v[8*i +: 8] = d[8*i +: 8];
      mem_m[a] = v;
   endtask

   // One pipeline access: runs until the cache stops stalling, answering
   // memory requests after `delay` wait cycles each.
   task automatic access(input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] width,
                         input int delay);
      int          waitc;
      logic [31:0] held;
      logic        done;
      bus.cpu_rd    = !wr;
      bus.cpu_wr    = wr;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wdata;
      bus.cpu_width = width;
      rq_addr.delete();
      rq_we.delete();
      l_stall  = 0;
      stab_err = 0;
      waitc    = 0;
      held     = '0;
      done     = 1'b0;
      l_rdata  = 'x;
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
         @(negedge clk);
         bus.mem_ack   = 1'b0;
         bus.mem_rdata = '0;
         if (bus.cpu_stall) l_stall++;
         if (bus.mem_req) begin
            if (waitc > 0 && bus.mem_addr !== held) stab_err++;
            held = bus.mem_addr;
            if (waitc == delay) begin
               bus.mem_ack = 1'b1;
               waitc = 0;
               rq_addr.push_back(bus.mem_addr);
               rq_we.push_back(bus.mem_we);
               if (bus.mem_we) begin
                  l_wdata = bus.mem_wdata;
                  l_wstrb = bus.mem_wstrb;
                  wmem(bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
               end else begin
                  bus.mem_rdata = memval(bus.mem_addr);
               end
            end else begin
               waitc++;
            end
         end
         if (!bus.cpu_stall) begin
            l_rdata = bus.cpu_rdata;
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      bus.mem_ack = 1'b0;
      bus.cpu_rd  = 1'b0;
      bus.cpu_wr  = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL timeout: addr=%h never released stall", addr);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.cpu_rd = 0; bus.cpu_wr = 0; bus.cpu_addr = 0;
      bus.cpu_wdata = 0; bus.cpu_width = 3'b010;
      bus.mem_ack = 0; bus.mem_rdata = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checks++; if ({bus.mem_req, bus.mem_we, bus.mem_wstrb} !== 6'b0) begin errors++; $display("FAIL rst_memctl: got %b want 0", {bus.mem_req, bus.mem_we, bus.mem_wstrb}); end
      checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", bus.mem_addr); end
      checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h want 0", bus.mem_wdata); end
      checks++; if (bus.cpu_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", bus.cpu_rdata); end
      checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", bus.cpu_stall); end
      checks++; if (bus.hit_count !== 0 || bus.miss_count !== 0) begin errors++; $display("FAIL rst_counts: got %0d/%0d want 0/0", bus.hit_count, bus.miss_count); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_refill();
      logic [31:0] exp_a;
      mem_m[32'h100] = 32'h11; mem_m[32'h104] = 32'h22;
      mem_m[32'h108] = 32'h33; mem_m[32'h10C] = 32'h44;
      access(1'b0, 32'h100, 0, 3'b010, 0);
      checks++; if (l_stall !== 5) begin errors++; $display("FAIL refill_stall: got %0d want 5", l_stall); end
      checks++; if (rq_addr.size() !== 4) begin errors++; $display("FAIL refill_nreq: got %0d want 4", rq_addr.size()); end
      for (int i = 0; i < 4; i++) begin
         exp_a = 32'h100 + 32'(i * 4);
         checks++; if (rq_addr[i] !== exp_a || rq_we[i] !== 1'b0) begin errors++; $display("FAIL refill_addr%0d: got %h we=%b want %h we=0", i, rq_addr[i], rq_we[i], exp_a); end
      end
      checks++; if (l_rdata !== 32'h11) begin errors++; $display("FAIL refill_rdata: got %h want 00000011", l_rdata); end
      checks++; if (bus.miss_count !== 1 || bus.hit_count !== 0) begin errors++; $display("FAIL refill_counts: got h=%0d m=%0d want 0/1", bus.hit_count, bus.miss_count); end
   endtask

   task automatic test_hit();
      access(1'b0, 32'h108, 0, 3'b010, 0);
      checks++; if (l_stall !== 0 || rq_addr.size() !== 0) begin errors++; $display("FAIL hit_nostall: got stall=%0d req=%0d want 0/0", l_stall, rq_addr.size()); end
      checks++; if (l_rdata !== 32'h33) begin errors++; $display("FAIL hit_rdata: got %h want 00000033", l_rdata); end
      checks++; if (bus.hit_count !== 1) begin errors++; $display("FAIL hit_count: got %0d want 1", bus.hit_count); end
   endtask

   task automatic test_store_hit();
      access(1'b1, 32'h101, 32'h80, 3'b000, 0);
      checks++; if (rq_addr.size() !== 1 || rq_addr[0] !== 32'h100 || rq_we[0] !== 1'b1) begin errors++; $display("FAIL sb_req: got n=%0d addr=%h want 1 write at 00000100", rq_addr.size(), rq_addr[0]); end
      checks++; if (l_wstrb !== 4'b0010) begin errors++; $display("FAIL sb_wstrb: got %b want 0010", l_wstrb); end
      checks++; if (l_wdata !== 32'h80808080) begin errors++; $display("FAIL sb_wdata: got %h want 80808080", l_wdata); end
      checks++; if (l_stall !== 2) begin errors++; $display("FAIL sb_stall: got %0d want 2", l_stall); end
      access(1'b0, 32'h101, 0, 3'b000, 0);
      checks++; if (l_rdata !== 32'hFFFFFF80 || l_stall !== 0) begin errors++; $display("FAIL lb_hit: got %h stall=%0d want ffffff80 stall=0", l_rdata, l_stall); end
      access(1'b0, 32'h101, 0, 3'b100, 0);
      checks++; if (l_rdata !== 32'h00000080 || l_stall !== 0) begin errors++; $display("FAIL lbu_hit: got %h stall=%0d want 00000080 stall=0", l_rdata, l_stall); end
      access(1'b0, 32'h100, 0, 3'b010, 0);
      checks++; if (l_rdata !== 32'h00008011) begin errors++; $display("FAIL lw_merged: got %h want 00008011", l_rdata); end
      access(1'b0, 32'h10E, 0, 3'b001, 0);
      checks++; if (l_rdata !== 32'h00000000) begin errors++; $display("FAIL lh_upper: got %h want 00000000", l_rdata); end
      checks++; if (bus.hit_count !== 5 || bus.miss_count !== 1) begin errors++; $display("FAIL sb_counts: got h=%0d m=%0d want 5/1", bus.hit_count, bus.miss_count); end
   endtask

   task automatic test_slow_refill();
      access(1'b0, 32'h340, 0, 3'b010, 3);
      checks++; if (l_stall !== 17) begin errors++; $display("FAIL slow_stall: got %0d want 17", l_stall); end
      checks++; if (stab_err !== 0) begin errors++; $display("FAIL slow_stable: got %0d changes want 0", stab_err); end
      checks++; if (rq_addr.size() !== 4 || rq_addr[3] !== 32'h34C) begin errors++; $display("FAIL slow_reqs: got n=%0d last=%h want 4 last=0000034c", rq_addr.size(), rq_addr[3]); end
      checks++; if (l_rdata !== 32'hA5A50340) begin errors++; $display("FAIL slow_rdata: got %h want a5a50340", l_rdata); end
      checks++; if (bus.miss_count !== 2) begin errors++; $display("FAIL slow_miss: got %0d want 2", bus.miss_count); end
   endtask

   task automatic test_reset_mid();
      bus.cpu_rd = 1'b1; bus.cpu_wr = 1'b0;
      bus.cpu_addr = 32'h5C0; bus.cpu_width = 3'b010;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (bus.mem_addr !== 32'h5C0 || bus.mem_req !== 1'b1) begin errors++; $display("FAIL rmid_w0: got %h req=%b want 000005c0 req=1", bus.mem_addr, bus.mem_req); end
      bus.mem_ack = 1'b1; bus.mem_rdata = memval(32'h5C0);
      @(posedge clk); #1;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      checks++; if (bus.mem_addr !== 32'h5C4) begin errors++; $display("FAIL rmid_w1: got %h want 000005c4", bus.mem_addr); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; bus.cpu_rd = 1'b0;
      @(negedge clk);
      checks++; if (bus.mem_req !== 1'b0 || bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL rmid_drop: got req=%b stall=%b want 0/0", bus.mem_req, bus.cpu_stall); end
      checks++; if (bus.miss_count !== 0 || bus.hit_count !== 0) begin errors++; $display("FAIL rmid_counts: got h=%0d m=%0d want 0/0", bus.hit_count, bus.miss_count); end
      @(posedge clk); #1;
      access(1'b0, 32'h5C0, 0, 3'b010, 0);
      checks++; if (l_stall !== 5 || l_rdata !== 32'hA5A505C0) begin errors++; $display("FAIL rmid_reload: got stall=%0d %h want 5 a5a505c0", l_stall, l_rdata); end
      access(1'b0, 32'h108, 0, 3'b010, 0);
      checks++; if (l_stall !== 5 || l_rdata !== 32'h33) begin errors++; $display("FAIL rmid_inval: got stall=%0d %h want 5 00000033", l_stall, l_rdata); end
      checks++; if (bus.miss_count !== 2) begin errors++; $display("FAIL rmid_miss: got %0d want 2", bus.miss_count); end
   endtask

   task automatic test_evict();
      access(1'b0, 32'h200, 0, 3'b010, 0);
      checks++; if (l_stall !== 5 || l_rdata !== 32'hA5A50200) begin errors++; $display("FAIL evict_new: got stall=%0d %h want 5 a5a50200", l_stall, l_rdata); end
      access(1'b0, 32'h100, 0, 3'b010, 0);
      checks++; if (l_stall !== 5 || l_rdata !== 32'h00008011) begin errors++; $display("FAIL evict_old: got stall=%0d %h want 5 00008011", l_stall, l_rdata); end
      checks++; if (bus.miss_count !== 4 || bus.hit_count !== 0) begin errors++; $display("FAIL evict_counts: got h=%0d m=%0d want 0/4", bus.hit_count, bus.miss_count); end
   endtask

   task automatic test_store_miss();
      access(1'b1, 32'h906, 32'h1234BEEF, 3'b001, 1);
      checks++; if (rq_addr.size() !== 1 || rq_addr[0] !== 32'h904) begin errors++; $display("FAIL sh_addr: got n=%0d %h want 1 00000904", rq_addr.size(), rq_addr[0]); end
      checks++; if (l_wstrb !== 4'b1100 || l_wdata !== 32'hBEEFBEEF) begin errors++; $display("FAIL sh_lanes: got %b %h want 1100 beefbeef", l_wstrb, l_wdata); end
      checks++; if (l_stall !== 3) begin errors++; $display("FAIL sh_stall: got %0d want 3", l_stall); end
      access(1'b0, 32'h104, 0, 3'b010, 0);
      checks++; if (l_stall !== 0 || l_rdata !== 32'h22) begin errors++; $display("FAIL noalloc_keep: got stall=%0d %h want 0 00000022", l_stall, l_rdata); end
      access(1'b0, 32'h904, 0, 3'b010, 0);
      checks++; if (l_stall !== 5 || l_rdata !== 32'hBEEF0904) begin errors++; $display("FAIL noalloc_miss: got stall=%0d %h want 5 beef0904", l_stall, l_rdata); end
      checks++; if (bus.hit_count !== 1 || bus.miss_count !== 5) begin errors++; $display("FAIL final_counts: got h=%0d m=%0d want 1/5", bus.hit_count, bus.miss_count); end
   endtask

   initial begin
      test_reset();
      test_refill();
      test_hit();
      test_store_hit();
      test_slow_refill();
      test_reset_mid();
      test_evict();
      test_store_miss();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
